// File: rtl/dotmatrix_scan_capture.sv
// Receive side of the 8x16 dot-matrix scan: watches row/col drive lines,
// rebuilds complete frames and serves them through a registered read port.
module dotmatrix_scan_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int FRAME_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             row_in,
  input  logic [15:0]            col_in,
  input  logic [2:0]             rd_row,
  output logic [15:0]            rd_data,
  output logic                   frame_done,
  output logic                   frame_drop,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   locked,
  output logic                   err_row
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);

  typedef enum logic {HUNT, CAPTURE} state_t;

  function automatic logic one_cold(input logic [7:0] r);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 8; i++) zeros += (r[i] ? 0 : 1);
    return (zeros == 1);
  endfunction

  function automatic logic [2:0] cold_idx(input logic [7:0] r);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) if (!r[i]) idx = 3'(i);
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= SETTLE) ? SETTLE : c + CNT_W'(1);
  endfunction

  logic [7:0]       row_q_p0, row_q_p1;
  logic [15:0]      col_q_p0, col_q_p1;
  logic [CNT_W-1:0] settle_cnt;
  logic             vld_p0, row_blank, row_illegal, stable, strobe;
  logic [2:0]       line;
  state_t           state, state_nx;
  logic [7:0]       mask;
  logic [15:0]      shadow  [8];
  logic [15:0]      display [8];
  logic             shadow_we, line0_strobe, mask_full, commit, drop;

  // Stage p0: registered drive lines; p1 holds the previous cycle for stability compare
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q_p0 <= 8'hFF;
      col_q_p0 <= '0;
      row_q_p1 <= 8'hFF;
      col_q_p1 <= '0;
    end else begin
      row_q_p0 <= row_in;
      col_q_p0 <= col_in;
      row_q_p1 <= row_q_p0;
      col_q_p1 <= col_q_p0;
    end
  end

  always_comb begin
    vld_p0      = one_cold(row_q_p0);
    row_blank   = &row_q_p0;
    row_illegal = !vld_p0 && !row_blank;
    line        = cold_idx(row_q_p0);
    stable      = (row_q_p0 == row_q_p1) && (col_q_p0 == col_q_p1);
    // Saturation at SETTLE leaves one strobe per visit until the pair changes
    strobe      = vld_p0 && stable && (settle_cnt == SETTLE - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      settle_cnt <= '0;
      err_row    <= 1'b0;
    end else begin
      settle_cnt <= (vld_p0 && stable) ? sat_inc(settle_cnt) : '0;
      if (row_illegal) err_row <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= HUNT;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == HUNT && strobe && line == 3'd0) state_nx = CAPTURE;
  end

  always_comb begin
    shadow_we    = (state == CAPTURE) && strobe;
    line0_strobe = strobe && (line == 3'd0);
    // Line 0 is written in the same cycle it is tested, so count it as present
    mask_full    = ((mask | 8'h01) == 8'hFF);
    commit       = (state == CAPTURE) && line0_strobe && mask_full;
    drop         = (state == CAPTURE) && line0_strobe && !mask_full;
  end

  // Stage p1: frame buffers, commit and status
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask        <= '0;
      frame_done  <= 1'b0;
      frame_drop  <= 1'b0;
      frame_count <= '0;
      locked      <= 1'b0;
      rd_data     <= '0;
      for (int i = 0; i < 8; i++) begin
        shadow[i]  <= '0;
        display[i] <= '0;
      end
    end else begin
      frame_done <= commit;
      frame_drop <= drop;
      rd_data    <= display[rd_row];
      if (shadow_we) shadow[line] <= col_q_p0;
      if (line0_strobe)   mask       <= '0;
      else if (shadow_we) mask[line] <= 1'b1;
      if (commit) begin
        display[0] <= col_q_p0;
        for (int i = 1; i < 8; i++) display[i] <= shadow[i];
        frame_count <= frame_count + FRAME_CNT_W'(1);
        locked      <= 1'b1;
      end
      if (drop) locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dotmatrix_scan_capture.sv
// Bench for dotmatrix_scan_capture: segment table with hand-derived end states,
// randomized scans against a run-length frame model, plus wrap and reset sequences.
module tb_dotmatrix_scan_capture;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  row_in = 8'hFF;
  logic [15:0] col_in = '0;
  logic [2:0]  rd_row = '0;
  logic [15:0] rd_data;
  logic        frame_done, frame_drop, locked, err_row;
  logic [7:0]  frame_count;

  always #5 clk = ~clk;

  dotmatrix_scan_capture #(.SETTLE_CYCLES(S), .FRAME_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_in(col_in), .rd_row(rd_row),
    .rd_data(rd_data), .frame_done(frame_done), .frame_drop(frame_drop),
    .frame_count(frame_count), .locked(locked), .err_row(err_row)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame state plus the run length of identical samples
  logic [7:0]  m_prow;
  logic [15:0] m_pcol;
  int          m_run;
  bit          m_hunt;
  logic [7:0]  m_mask;
  logic [15:0] m_shadow [8];
  logic [15:0] m_disp   [8];
  int          m_cnt;
  bit          m_locked, m_err;
  bit          p_vld, p_ill;
  int          p_line;
  logic [15:0] p_col;

  typedef struct {
    logic [7:0]  row;
    logic [15:0] col;
    int          hold;
    logic [2:0]  rd;
    bit          chk;
    logic [7:0]  e_cnt;
    bit          e_lock;
    bit          e_err;
    logic [15:0] e_rd;
  } seg_t;
  seg_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] line_row(input int l);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << l);
  endfunction

  task automatic model_reset();
    m_prow = 8'hFF; m_pcol = '0; m_run = 0; m_hunt = 1; m_mask = '0;
    for (int i = 0; i < 8; i++) begin m_shadow[i] = '0; m_disp[i] = '0; end
    m_cnt = 0; m_locked = 0; m_err = 0; p_vld = 0; p_ill = 0; p_line = 0; p_col = '0;
  endtask

  task automatic step(input logic [7:0] r, input logic [15:0] c, input logic [2:0] rr,
                      input logic rst_v);
    logic [15:0] exp_rd;
    bit e_done, e_drop;
    int zeros, idx;
    row_in = r; col_in = c; rd_row = rr; rst = rst_v;
    @(posedge clk); #1;
    e_done = 0; e_drop = 0;
    if (!rst_v) begin
      model_reset();
      exp_rd = '0;
    end else begin
      exp_rd = m_disp[rr];
      if (p_ill) m_err = 1;
      if (p_vld) begin
        if (m_hunt) begin
          if (p_line == 0) begin m_hunt = 0; m_mask = '0; end
        end else begin
          m_shadow[p_line] = p_col;
          m_mask[p_line] = 1'b1;
          if (p_line == 0) begin
            if (m_mask == 8'hFF) begin
              for (int i = 0; i < 8; i++) m_disp[i] = m_shadow[i];
              m_cnt = (m_cnt + 1) % 256; m_locked = 1; e_done = 1;
            end else begin
              m_locked = 0; e_drop = 1;
            end
            m_mask = '0;
          end
        end
      end
      zeros = 0; idx = 0;
      for (int i = 0; i < 8; i++) if (!r[i]) begin zeros++; idx = i; end
      if (zeros == 1) m_run = (r == m_prow && c == m_pcol) ? m_run + 1 : 1;
      else            m_run = 0;
      m_prow = r; m_pcol = c;
      p_vld = (m_run == S + 1);
      p_line = idx; p_col = c;
      p_ill = (zeros > 1);
    end
    chk("rd_data", rd_data, exp_rd);
    chk("frame_done", frame_done, e_done);
    chk("frame_drop", frame_drop, e_drop);
    chk("frame_count", frame_count, m_cnt[7:0]);
    chk("locked", locked, m_locked);
    chk("err_row", err_row, m_err);
    checks++;
    if (frame_done && frame_drop) begin
      errors++;
      $display("FAIL done_and_drop: got both high expected at most one");
    end
  endtask

  task automatic run_seg(input logic [7:0] r, input logic [15:0] c, input int h, input logic [2:0] rr);
    for (int i = 0; i < h; i++) step(r, c, rr, 1'b1);
  endtask

  task automatic good_frame(input logic [15:0] base, input int h, input logic [2:0] rr);
    for (int l = 7; l >= 0; l--) run_seg(line_row(l), base + 16'(l), h, rr);
  endtask

  task automatic add(input logic [7:0] r, input logic [15:0] c, input int h, input logic [2:0] rd,
                     input bit ck, input logic [7:0] ec, input bit el, input bit ee,
                     input logic [15:0] er);
    seg_t s;
    s.row = r; s.col = c; s.hold = h; s.rd = rd; s.chk = ck;
    s.e_cnt = ec; s.e_lock = el; s.e_err = ee; s.e_rd = er;
    tbl.push_back(s);
  endtask

  task automatic add_frame(input logic [15:0] base, input int skip, input bit ill,
                           input logic [2:0] rd, input logic [7:0] ec, input bit el,
                           input bit ee, input logic [15:0] er);
    for (int l = 7; l >= 1; l--) begin
      if (l == skip) add(8'b1111_0011, 16'h0, 10, rd, 0, 0, 0, 0, 0);
      else add(line_row(l), base + 16'(l), 10, rd, 0, 0, 0, 0, 0);
      if (l == 4 && ill) add(8'b1111_0011, 16'h0, 10, rd, 0, 0, 0, 0, 0);
    end
    add(line_row(0), base, 10, rd, 1, ec, el, ee, er);
  endtask

  initial begin
    model_reset();
    // First scan: line 3 carries 0007, everything else 0
    add(8'hFF, 16'h0, 10, 3'd0, 1, 8'd0, 0, 0, 16'h0);
    add(line_row(0), 16'h0, 10, 3'd0, 1, 8'd0, 0, 0, 16'h0);
    for (int l = 7; l >= 1; l--) add(line_row(l), (l == 3) ? 16'h0007 : 16'h0, 10, 3'd3, 0, 0, 0, 0, 0);
    add(line_row(0), 16'h0, 10, 3'd3, 1, 8'd1, 1, 0, 16'h0007);
    add(8'hFF, 16'h0, 10, 3'd5, 1, 8'd1, 1, 0, 16'h0);
    // Line 4 held S-1 cycles; line 3 data must not reach the display
    for (int l = 7; l >= 5; l--) add(line_row(l), 16'h0, 10, 3'd3, 0, 0, 0, 0, 0);
    add(line_row(4), 16'h0, S - 1, 3'd3, 0, 0, 0, 0, 0);
    add(line_row(3), 16'hFFFF, 10, 3'd3, 0, 0, 0, 0, 0);
    for (int l = 2; l >= 1; l--) add(line_row(l), 16'h0, 10, 3'd3, 0, 0, 0, 0, 0);
    add(line_row(0), 16'h0, 10, 3'd3, 1, 8'd1, 0, 0, 16'h0007);
    add(8'hFF, 16'h0, 80, 3'd2, 0, 0, 0, 0, 0);
    add_frame(16'h1000, -1, 0, 3'd2, 8'd2, 1, 0, 16'h1002);
    add(8'hFF, 16'h0, 80, 3'd7, 0, 0, 0, 0, 0);
    add_frame(16'h2000, -1, 0, 3'd7, 8'd3, 1, 0, 16'h2007);
    add_frame(16'h3000, -1, 1, 3'd4, 8'd4, 1, 1, 16'h3004);
    add_frame(16'h4000, -1, 0, 3'd0, 8'd5, 1, 1, 16'h4000);
    add_frame(16'h5000, 4, 0, 3'd6, 8'd5, 0, 1, 16'h4006);
    // Last table frame holds line 4 exactly S+1 cycles, the shortest capturing visit
    for (int l = 7; l >= 5; l--) add(line_row(l), 16'h6000 + 16'(l), 10, 3'd1, 0, 0, 0, 0, 0);
    add(line_row(4), 16'h6004, S + 1, 3'd1, 0, 0, 0, 0, 0);
    for (int l = 3; l >= 1; l--) add(line_row(l), 16'h6000 + 16'(l), 10, 3'd1, 0, 0, 0, 0, 0);
    add(line_row(0), 16'h6000, 10, 3'd1, 1, 8'd6, 1, 1, 16'h6001);

    for (int i = 0; i < 3; i++) step(8'hFF, 16'h0, 3'd0, 1'b0);
    chk("reset_count", frame_count, 8'd0);
    chk("reset_locked", locked, 1'b0);
    chk("reset_rd", rd_data, 16'h0);

    foreach (tbl[k]) begin
      run_seg(tbl[k].row, tbl[k].col, tbl[k].hold, tbl[k].rd);
      if (tbl[k].chk) begin
        chk("seg_count", frame_count, tbl[k].e_cnt);
        chk("seg_locked", locked, tbl[k].e_lock);
        chk("seg_err", err_row, tbl[k].e_err);
        chk("seg_rd", rd_data, tbl[k].e_rd);
      end
    end

    // Randomized scans: short holds, blanks, illegal rows and mid-visit data changes
    for (int f = 0; f < 40; f++) begin
      for (int l = 7; l >= 0; l--) begin
        if ($urandom_range(3) == 0)
          for (int i = 0; i < int'($urandom_range(12, 1)); i++) step(8'hFF, 16'(($urandom)), 3'($urandom), 1'b1);
        if ($urandom_range(15) == 0)
          for (int i = 0; i < 6; i++) step(8'(($urandom)) | 8'b0000_0011 & 8'b1111_0011, 16'h0, 3'($urandom), 1'b1);
        begin
          logic [15:0] c;
          int h;
          c = 16'($urandom);
          h = int'($urandom_range(S + 4, S - 1));
          for (int i = 0; i < h; i++) step(line_row(l), c, 3'($urandom), 1'b1);
          if ($urandom_range(7) == 0)
            for (int i = 0; i < S + 2; i++) step(line_row(l), ~c, 3'($urandom), 1'b1);
        end
      end
    end

    // Counter wrap over 256 committed frames
    step(8'hFF, 16'h0, 3'd0, 1'b0);
    step(8'hFF, 16'h0, 3'd0, 1'b0);
    run_seg(line_row(0), 16'h0, 6, 3'd0);
    for (int f = 1; f <= 256; f++) begin
      good_frame(16'(($urandom)) & 16'hFFF0, 6, 3'(f));
      if (f == 255) chk("wrap_ff", frame_count, 8'hFF);
    end
    chk("wrap_done", frame_done, 1'b1);
    chk("wrap_zero", frame_count, 8'h00);
    chk("wrap_locked", locked, 1'b1);

    // Reset in the middle of a frame, then re-hunt
    for (int l = 7; l >= 5; l--) run_seg(line_row(l), 16'h00A0, 10, 3'd2);
    run_seg(line_row(4), 16'h00A0, 3, 3'd2);
    step(line_row(4), 16'h00A0, 3'd2, 1'b0);
    step(line_row(4), 16'h00A0, 3'd2, 1'b0);
    chk("mid_rst_count", frame_count, 8'd0);
    chk("mid_rst_done", frame_done, 1'b0);
    chk("mid_rst_drop", frame_drop, 1'b0);
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_err", err_row, 1'b0);
    chk("mid_rst_rd", rd_data, 16'h0);
    run_seg(line_row(4), 16'h00A0, 5, 3'd2);
    for (int l = 3; l >= 1; l--) run_seg(line_row(l), 16'h00A0, 10, 3'd2);
    run_seg(line_row(0), 16'h00A0, 10, 3'd2);
    chk("hunt_count", frame_count, 8'd0);
    good_frame(16'h7700, 10, 3'd2);
    chk("rehunt_count", frame_count, 8'd1);
    chk("rehunt_locked", locked, 1'b1);
    chk("rehunt_rd", rd_data, 16'h7702);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dotmatrix_scan_capture.md
Name: dotmatrix_scan_capture

Overview:
- Receive-side counterpart of the 8x16 dot-matrix scan driver.
- Monitors the multiplexed row/col drive lines (row active-low one-hot, col active-high), reconstructs complete frames into an internal 8x16 buffer, and exposes them through a registered read port.
- Used for on-chip self-check of the game display and as the source for a mirrored secondary display.

Parameters:
- SETTLE_CYCLES, 4, consecutive clk cycles a row/col pair must stay unchanged before it is captured (range 1..255).
- FRAME_CNT_W, 8, width of the frame counter.

Ports:
- clk  input  1  system clock; same domain as the scan driver.
- rst  input  1  reset, synchronous, active-low.
- row_in  input  8  observed row drive; active-low one-hot selects a line.
- col_in  input  16  observed column data for the selected line.
- rd_row  input  3  read-port line index.
- rd_data  output  16  captured column data for line rd_row.
- frame_done  output  1  one-cycle pulse when a complete frame is committed.
- frame_drop  output  1  one-cycle pulse when an incomplete frame is discarded.
- frame_count  output  FRAME_CNT_W  number of committed frames.
- locked  output  1  high while captured frames are complete and consecutive.
- err_row  output  1  sticky flag for an illegal row pattern.

Behaviour:
- Reset (rst=0 at a clk edge) clears all of the following; reset mid-frame discards any partial frame with no frame_drop pulse:
  - outputs: rd_data, frame_done, frame_drop, frame_count, locked, err_row all 0
  - shadow and display buffers all 0
  - written-mask 0, settle counter 0, FSM=HUNT
- Input stage: row_in and col_in registered once (row_q, col_q). All decoding uses row_q/col_q.
- Row classification of row_q:
  - exactly one bit 0 -> VALID, line index = position of that 0 bit
  - all ones -> BLANK (normal; the driver's 4-bit scanline produces 8 blank slots per 16)
  - anything else -> ILLEGAL: set err_row (sticky until reset), clear settle counter, otherwise treat as BLANK
- Settle counter:
  - increments while row_q and col_q equal their previous-cycle values and the row is VALID
  - any change, BLANK or ILLEGAL clears it
  - saturates at SETTLE_CYCLES
  - the capture strobe fires on the cycle the count reaches SETTLE_CYCLES; only one strobe per line visit, re-armed after row_q changes.
- FSM:
  - HUNT: ignore strobes until a strobe on line 0 (end of a driver frame; the driver scans 7 down to 0). Then clear mask and go to CAPTURE. No buffer write on this strobe.
  - CAPTURE: on strobe for line L:
    - write col_q into shadow[L] and set mask[L]
    - repeated capture of the same line overwrites it
  - CAPTURE, line-0 strobe handling: the line-0 write happens first, then the mask is tested:
    - mask == 8'hFF: copy shadow to display buffer in one cycle, pulse frame_done, frame_count += 1 (wraps at all-ones to 0), set locked.
    - otherwise: pulse frame_drop, clear locked, no copy.
    - either case: clear mask, stay in CAPTURE.
- frame_done/frame_drop pulse on the cycle after the strobe; never both in one cycle.
- Read port:
  - rd_data <= display[rd_row] every cycle (1-cycle latency).
  - On a commit cycle the read returns pre-commit data; new data is visible from the following read.
- Latency from the line-0 row_in change to frame_done: 1 (input reg) + SETTLE_CYCLES + 1 cycles.

Test Plan:
- Reset, then drive a full 7..0 scan with col=16'h0007 on line 3, 0 elsewhere, each line held 10 cycles, preceded by one line-0 visit -> exactly one frame_done, frame_count=1, locked=1, rd_row=3 reads 16'h0007 next cycle, rd_row=5 reads 0.
- Line held only SETTLE_CYCLES-1 cycles (line 4 held 3 cycles at default) during a frame -> frame_drop at line 0, locked=0, frame_count unchanged, display buffer keeps the previous frame.
- Insert 8 all-ones blank slots of 10 cycles between frames -> no error, no drop, frame_count increments by 1 per frame.
- row_in=8'b1111_0011 for one slot mid-frame -> err_row=1 and stays 1 through later good frames; frame containing it drops only if a line was missed.
- Run 256 good frames -> frame_count wraps 8'hFF -> 8'h00 with frame_done still pulsing.
- Assert rst while mid-frame, then release -> all outputs 0, first line-0 strobe produces no frame_done (HUNT), next full frame commits with frame_count=1.
